// File: rtl/pitch_meter_pkg.sv
// pitch_meter_pkg: shared types and constants for the pitch meter.
//   state_e    - measurement FSM states
//   DEF_WIDTH  - default period counter / result width
//   AVG_DEPTH  - number of half-periods averaged when PITCH_METER_AVG_EN is defined
//   AVG_SHIFT  - log2(AVG_DEPTH), the divide-by-depth shift
package pitch_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int AVG_DEPTH = 4;
  localparam int AVG_SHIFT = 2;

endpackage

// File: rtl/pitch_meter_sync_edge_detect.sv
// sync_edge_detect: two-flop synchronizer plus history flop for an
// asynchronous input, producing a one-cycle pulse on either edge.
// Also suitable for button inputs.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   d_i    - asynchronous input
//   edge_o - one-cycle pulse on any edge of the synchronized input
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic edge_o
);

  logic sync1_q, sync2_q, hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign edge_o = sync2_q ^ hist_q;

endmodule

// File: rtl/pitch_meter.sv
// pitch_meter: measures the half-period of a square-wave input in clk
// cycles and hands each result out over a valid/ready handshake.
// Optional: define PITCH_METER_AVG_EN to report the floor average of the
// last AVG_DEPTH half-periods instead of the raw measurement.
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset
//   sig_in  - asynchronous square-wave input
//   period  - last reported half-period
//   valid   - period holds an unconsumed result
//   ready   - consumer accepts when valid && ready
//   silent  - no edge within MAX_COUNT cycles, or none since reset
//   overrun - a result was overwritten before being accepted
//
// state   | meaning
// IDLE    | no interval in progress; next edge only arms
// MEASURE | counting cycles since the last edge
module pitch_meter
  import pitch_meter_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_COUNT = (2 ** WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  input  logic             ready,
  output logic             silent,
  output logic             overrun
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic             edge_w;
  state_e           state_q;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q;
  logic             valid_q, silent_q, overrun_q;
  logic             meas_edge_w, timeout_w, new_result_w;
  logic [WIDTH-1:0] result_w;

  sync_edge_detect u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (sig_in),
    .edge_o (edge_w)
  );

  always_comb begin
    meas_edge_w = edge_w && (state_q == MEASURE);
    // An edge landing on the terminal count still counts as a measurement.
    timeout_w   = !edge_w && (state_q == MEASURE) && (cnt_q == MAX_CNT);
    if (edge_w)                cnt_d = CNT_ONE;
    else if (cnt_q == MAX_CNT) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + CNT_ONE;
  end

`ifdef PITCH_METER_AVG_EN
  // The current count plus AVG_DEPTH-1 stored half-periods form the window.
  localparam logic [AVG_SHIFT-1:0] FILL_FULL = AVG_SHIFT'(AVG_DEPTH - 1);

  logic [WIDTH-1:0]           hist_q [AVG_DEPTH-1];
  logic [AVG_SHIFT-1:0]       fill_q;
  logic [WIDTH+AVG_SHIFT-1:0] sum_w;

  always_comb begin
    sum_w = (WIDTH + AVG_SHIFT)'(cnt_q);
    for (int i = 0; i < AVG_DEPTH - 1; i++) begin
      sum_w = sum_w + (WIDTH + AVG_SHIFT)'(hist_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
      for (int i = 0; i < AVG_DEPTH - 1; i++) hist_q[i] <= '0;
    end else if (timeout_w) begin
      fill_q <= '0;
      for (int i = 0; i < AVG_DEPTH - 1; i++) hist_q[i] <= '0;
    end else if (meas_edge_w) begin
      hist_q[0] <= cnt_q;
      for (int i = 1; i < AVG_DEPTH - 1; i++) hist_q[i] <= hist_q[i-1];
      if (fill_q != FILL_FULL) fill_q <= fill_q + AVG_SHIFT'(1);
    end
  end

  assign new_result_w = meas_edge_w && (fill_q == FILL_FULL);
  assign result_w     = WIDTH'(sum_w >> AVG_SHIFT);
`else
  assign new_result_w = meas_edge_w;
  assign result_w     = cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      silent_q  <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: begin
          if (edge_w) state_q <= MEASURE;
        end
        MEASURE: begin
          if (timeout_w) begin
            state_q  <= IDLE;
            silent_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (new_result_w) begin
        period_q <= result_w;
        valid_q  <= 1'b1;
        silent_q <= 1'b0;
        if (valid_q && !ready)     overrun_q <= 1'b1;
        else if (valid_q && ready) overrun_q <= 1'b0;
      end else if (valid_q && ready) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

  assign period  = period_q;
  assign valid   = valid_q;
  assign silent  = silent_q;
  assign overrun = overrun_q;

endmodule

// File: doc/pitch_meter.md
Name: pitch_meter

Overview:
- Measures the half-period of a square-wave audio signal, such as a single-pitch oscillator output or a voice mix, in clk cycles.
- Acts as the receive-side counterpart of the pitch oscillators: it recovers the PITCH count from the waveform.
- Sits between an audio/test input pin and downstream logic (note decode, LED display, self-test).
- Delivers each result over a valid/ready handshake.

Parameters:
- WIDTH, 16, width of the period counter and result; 15289 fits.
- MAX_COUNT, 2**WIDTH-1, cycle count without an edge after which the input is declared silent; must be at most 2**WIDTH-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- sig_in  input  1  asynchronous square-wave input
- period  output  WIDTH  last measured half-period in clk cycles
- valid  output  1  period holds an unconsumed result
- ready  input  1  consumer accepts the result when valid&&ready
- silent  output  1  no edge seen for MAX_COUNT cycles, or none since reset
- overrun  output  1  a result was overwritten before it was accepted

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - period=0, valid=0, overrun=0, silent=1.
  - Synchronizer flops=0, cnt=0, state=IDLE.
- Input path:
  - sig_in passes through 2 sync flops plus 1 history flop.
  - edge = sync2 ^ hist, so both edges count.
  - An edge pulse appears 3 clk after the sig_in transition.
- Counter cnt (WIDTH bits): on edge, cnt<=1; otherwise cnt<=cnt+1, saturating at MAX_COUNT.
- Measurement rule: a synchronized signal toggling every P cycles reports P.
- FSM, IDLE:
  - No report is made.
  - On edge: go to MEASURE, cnt<=1 (arming edge).
- FSM, MEASURE:
  - On edge: report cnt as a new result, cnt<=1.
  - Else if cnt==MAX_COUNT: go to IDLE, silent<=1.
  - If edge and cnt==MAX_COUNT occur in the same cycle, the edge wins and MAX_COUNT is reported.
- Result register:
  - On a new result: period<=result, valid<=1 on the next clk, silent<=0.
  - If valid&&!ready in that cycle: overrun<=1, and the old value is lost.
- Handshake:
  - valid&&ready with no new result: valid<=0, overrun<=0.
  - valid&&ready together with a new result: valid stays 1, period takes the new value, overrun<=0.
  - period holds its value while valid=0. It is not cleared on silence.
- Going silent does not clear valid; any pending result stays until accepted.
- Reset mid-interval discards the partial count. The first edge after reset release only arms the FSM.

Optional Feature:
- PITCH_METER_AVG_EN defined:
  - The reported value is the floor of the sum of the last 4 measured half-periods, divided by 4. The sum is WIDTH+2 bits and the result is the sum shifted right by 2.
  - Nothing is reported until 4 measurements exist since arming.
  - History and its fill count clear on reset and on entering IDLE.
  - Reporting cadence after fill is unchanged: one result per edge.
- PITCH_METER_AVG_EN undefined: the raw per-edge measurement is reported, and no history storage is synthesized.

Decomposition:
- Package pitch_meter_pkg holds:
  - the FSM state enum {IDLE, MEASURE};
  - the default WIDTH constant;
  - the AVG_DEPTH=4 constant and its log2 shift of 2.
- Natural sub-module: sync_edge_detect, containing the 2-flop synchronizer, history flop and any-edge pulse. It is reusable for the button inputs.

Test Plan:
- Steady pitch: sig_in toggles every 15289 clk, ready=1.
  - No result for the arming edge, then period=15289 with valid for one cycle per edge.
  - silent falls after the first result.
- Pitch change: 3 half-periods of 13621, then toggle every 12135.
  - Results read 13621, 13621, then 12135 from the first full new interval.
  - No intermediate garbage values.
- Silence (WIDTH=8, MAX_COUNT=255): run at 100-cycle half-periods, then hold sig_in.
  - silent=1 exactly 255 cycles after the last edge, with no spurious valid.
  - The next edge only arms; the second edge reports.
- Backpressure: ready=0 across results 100, 110, 120.
  - period=120, valid=1, overrun=1.
  - One cycle of ready=1 then gives valid=0, overrun=0.
  - Simultaneous accept plus new result keeps valid=1 with the new value and overrun=0.
- Reset mid-interval: assert rst_n=0 at cnt=50.
  - Outputs clear asynchronously, silent=1.
  - After release, the first edge arms and the second reports the correct P.
- With PITCH_METER_AVG_EN: half-periods 100, 102, 104, 106.
  - First report 103 after the 4th measurement.
  - Next half-period 110 reports 105.
